// File: rtl/rtc_disp_fmt_pkg.sv
// Shared types and constants for the RTC display formatter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: mode and FSM enums, snapshot struct, blank/dp constants,
// edit-field codes, and a BCD range check used when FMT_BCD_CHECK_EN is defined.
package rtc_fmt_pkg;

    typedef enum logic {
        MODE_HM,
        MODE_MS
    } mode_e;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_LIVE,
        ST_STALE
    } state_e;

    // Latched time snapshot, all fields BCD {tens,ones}
    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] mn;
        logic [7:0] sc;
    } snap_t;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic       DP_OFF      = 1'b1;

    localparam logic [1:0] FIELD_SEC   = 2'd0;
    localparam logic [1:0] FIELD_MIN   = 2'd1;
    localparam logic [1:0] FIELD_HOUR  = 2'd2;
    localparam logic [1:0] FIELD_NONE  = 2'd3;

    // True when sec/min are 00..59 and hour is 00..23 in valid BCD
    function automatic logic bcd_ok(input logic [7:0] s, input logic [7:0] m,
                                    input logic [7:0] h);
        return (s[3:0] <= 4'd9) && (s[7:4] <= 4'd5) &&
               (m[3:0] <= 4'd9) && (m[7:4] <= 4'd5) &&
               (h[3:0] <= 4'd9) && (h <= 8'h23);
    endfunction

endpackage

// File: rtl/rtc_disp_fmt_pulse_div.sv
// Free-running cycle divider: tick_o is high for one cycle every DIV cycles.
// Latency: first tick DIV-1 cycles after reset release or after clr_i.
// Backpressure: none; clr_i restarts the count from zero on the next cycle.
// Ports: clk, rst (async, active-high), clr_i (sync restart), tick_o (wrap pulse).
module pulse_div #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap   = (cnt_q == CW'(DIV - 1));
    // Pulse follows the count even on a clr_i cycle; callers give clr_i priority
    assign tick_o = wrap;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_disp_fmt.sv
// Formats the RTC BCD snapshot into 4 FND digit bytes, colon/dp bits and the scan tick.
// Latency: 1 cycle from time_valid / mode_btn to digit outputs; blanking is combinational.
// Backpressure: none; every time_valid strobe is taken (or rejected if FMT_BCD_CHECK_EN).
// Ports: time_valid/sec/min/hour snapshot in, mode_btn, edit_en/edit_sel in;
// scan_tick, d0..d3 (d0 rightmost, 8'h0F = blank), dot (active-low: [1] colon, [0] dp), stale out.
// Build option: FMT_BCD_CHECK_EN rejects out-of-range BCD snapshots and adds the sticky bad_bcd output.
module rtc_disp_fmt
    import rtc_fmt_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1_000,
    parameter int unsigned BLINK_HZ = 2,
    parameter int unsigned STALE_MS = 2_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       time_valid,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    input  logic       mode_btn,
    input  logic       edit_en,
    input  logic [1:0] edit_sel,
    output logic       scan_tick,
    output logic [7:0] d0,
    output logic [7:0] d1,
    output logic [7:0] d2,
    output logic [7:0] d3,
    output logic [1:0] dot,
    output logic       stale
`ifdef FMT_BCD_CHECK_EN
    ,
    output logic       bad_bcd
`endif
);

    localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned BLINK_DIV = CLK_HZ / BLINK_HZ;
    localparam int unsigned MS_DIV    = CLK_HZ / 1000;
    localparam int unsigned WD_W      = $clog2(STALE_MS + 1);

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    snap_t           snap_q, snap_d;
    logic            phase_on_q, phase_on_d;
    logic            edit_en_q;
    logic [1:0]      edit_sel_q;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    logic            tv_ok;
    logic            restart;
    logic            phase_eff;
    logic            blink_tick;
    logic            ms_tick;
    logic            wd_expire;
    logic [7:0]      disp_hi, disp_lo;
    logic            blank_hi, blank_lo;

    // ---------------------------------------------------------------
    // Snapshot acceptance
    // ---------------------------------------------------------------
`ifdef FMT_BCD_CHECK_EN
    logic bad_bcd_q;

    assign tv_ok   = time_valid && bcd_ok(sec, min, hour);
    assign bad_bcd = bad_bcd_q;

    // Sticky until reset so firmware can see a past corrupt read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_bcd_q <= 1'b0;
        end else if (time_valid && !tv_ok) begin
            bad_bcd_q <= 1'b1;
        end
    end
`else
    assign tv_ok = time_valid;
`endif

    // ---------------------------------------------------------------
    // Timebases
    // ---------------------------------------------------------------
    pulse_div #(.DIV(SCAN_DIV)) u_scan_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (1'b0),
        .tick_o (scan_tick)
    );

    // Entering edit or moving to another field restarts the blink so the
    // newly selected field is visible immediately
    assign restart = (edit_en && !edit_en_q) || (edit_sel != edit_sel_q);

    pulse_div #(.DIV(BLINK_DIV)) u_blink_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (restart),
        .tick_o (blink_tick)
    );

    // Millisecond base for the watchdog, re-aligned to every accepted snapshot
    pulse_div #(.DIV(MS_DIV)) u_ms_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tv_ok),
        .tick_o (ms_tick)
    );

    assign wd_expire = ms_tick && (wd_cnt_q == WD_W'(STALE_MS - 1));

    // ---------------------------------------------------------------
    // Datapath next-state
    // ---------------------------------------------------------------
    always_comb begin
        snap_d     = snap_q;
        mode_d     = mode_q;
        phase_on_d = phase_on_q;
        wd_cnt_d   = wd_cnt_q;

        if (tv_ok) begin
            snap_d = '{hr: hour, mn: min, sc: sec};
        end

        if (mode_btn) begin
            mode_d = (mode_q == MODE_HM) ? MODE_MS : MODE_HM;
        end

        if (restart) begin
            phase_on_d = 1'b1;
        end else if (blink_tick) begin
            phase_on_d = !phase_on_q;
        end

        // Saturates at STALE_MS so it cannot wrap while stale
        if (tv_ok) begin
            wd_cnt_d = '0;
        end else if (ms_tick && (wd_cnt_q != WD_W'(STALE_MS))) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            mode_q     <= MODE_HM;
            snap_q     <= '0;
            phase_on_q <= 1'b1;
            edit_en_q  <= 1'b0;
            edit_sel_q <= FIELD_NONE;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            snap_q     <= snap_d;
            phase_on_q <= phase_on_d;
            edit_en_q  <= edit_en;
            edit_sel_q <= edit_sel;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    // ---------------------------------------------------------------
    // Digit selection and edit blanking
    // ---------------------------------------------------------------
    // On a restart cycle the phase register has not yet been forced ON
    assign phase_eff = restart ? 1'b1 : phase_on_q;

    always_comb begin
        disp_hi  = snap_q.hr;
        disp_lo  = snap_q.mn;
        blank_hi = 1'b0;
        blank_lo = 1'b0;

        if (mode_q == MODE_MS) begin
            disp_hi = snap_q.mn;
            disp_lo = snap_q.sc;
        end

        // Only a field currently on the display can blink
        if (edit_en && !phase_eff) begin
            if (mode_q == MODE_HM) begin
                blank_hi = (edit_sel == FIELD_HOUR);
                blank_lo = (edit_sel == FIELD_MIN);
            end else begin
                blank_hi = (edit_sel == FIELD_MIN);
                blank_lo = (edit_sel == FIELD_SEC);
            end
        end
    end

    // ---------------------------------------------------------------
    // Freshness FSM and outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        d3      = {4'h0, DIGIT_BLANK};
        d2      = {4'h0, DIGIT_BLANK};
        d1      = {4'h0, DIGIT_BLANK};
        d0      = {4'h0, DIGIT_BLANK};
        dot     = {DP_OFF, DP_OFF};
        stale   = 1'b1;

        unique case (state_q)
            ST_WAIT: begin
                if (tv_ok) begin
                    state_d = ST_LIVE;
                end
            end
            ST_LIVE: begin
                if (!tv_ok && wd_expire) begin
                    state_d = ST_STALE;
                end
                stale  = 1'b0;
                d3     = {4'h0, blank_hi ? DIGIT_BLANK : disp_hi[7:4]};
                d2     = {4'h0, blank_hi ? DIGIT_BLANK : disp_hi[3:0]};
                d1     = {4'h0, blank_lo ? DIGIT_BLANK : disp_lo[7:4]};
                d0     = {4'h0, blank_lo ? DIGIT_BLANK : disp_lo[3:0]};
                // Colon held steady during edit so the blinking field stands out
                dot[1] = (edit_en || phase_eff) ? 1'b0 : DP_OFF;
                dot[0] = edit_en ? 1'b0 : DP_OFF;
            end
            ST_STALE: begin
                if (tv_ok) begin
                    state_d = ST_LIVE;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_disp_fmt.sv
// Self-checking bench for rtc_disp_fmt with scaled-down clock parameters.
module tb_rtc_disp_fmt;

    localparam int CLK_HZ   = 10_000;
    localparam int SCAN_HZ  = 1_000;
    localparam int BLINK_HZ = 50;
    localparam int STALE_MS = 30;
    localparam int SDIV     = CLK_HZ / SCAN_HZ;        // cycles per scan tick
    localparam int BDIV     = CLK_HZ / BLINK_HZ;       // cycles per blink phase
    localparam int TSTALE   = STALE_MS * (CLK_HZ / 1000); // cycles to stale

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       time_valid = 1'b0;
    logic [7:0] sec = 8'h00, min = 8'h00, hour = 8'h00;
    logic       mode_btn = 1'b0;
    logic       edit_en = 1'b0;
    logic [1:0] edit_sel = 2'd3;
    logic       scan_tick;
    logic [7:0] d0, d1, d2, d3;
    logic [1:0] dot;
    logic       stale;
`ifdef FMT_BCD_CHECK_EN
    logic       bad_bcd;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rtc_disp_fmt #(
        .CLK_HZ   (CLK_HZ),
        .SCAN_HZ  (SCAN_HZ),
        .BLINK_HZ (BLINK_HZ),
        .STALE_MS (STALE_MS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .time_valid (time_valid),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .mode_btn   (mode_btn),
        .edit_en    (edit_en),
        .edit_sel   (edit_sel),
        .scan_tick  (scan_tick),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .dot        (dot),
        .stale      (stale)
`ifdef FMT_BCD_CHECK_EN
        ,
        .bad_bcd    (bad_bcd)
`endif
    );

    wire [35:0] got = {d3, d2, d1, d0, dot, stale, scan_tick};

    // ---------------- reference model ----------------
    int         m_edges;     // clock edges since reset release
    int         m_blink_t;   // edges since last blink restart (or reset)
    int         m_since_tv;  // edges since last accepted snapshot
    bit         m_have;      // any snapshot accepted since reset
    bit         m_ms;        // 1 = MM:SS mode
    bit         m_prev_en;
    logic [1:0] m_prev_sel;
    logic [7:0] m_h, m_m, m_s;
    bit         m_bad;

    function automatic bit bcd_valid(input logic [7:0] s, input logic [7:0] m,
                                     input logic [7:0] h);
        int sv, mv, hv;
        if (s[3:0] > 9 || m[3:0] > 9 || h[3:0] > 9) return 0;
        sv = s[7:4] * 10 + s[3:0];
        mv = m[7:4] * 10 + m[3:0];
        hv = h[7:4] * 10 + h[3:0];
        return (sv < 60) && (mv < 60) && (hv < 24) && (h[7:4] <= 9);
    endfunction

    task automatic model_reset();
        m_edges = 0; m_blink_t = 0; m_since_tv = 0; m_have = 0; m_ms = 0;
        m_prev_en = 0; m_prev_sel = 2'd3; m_h = 0; m_m = 0; m_s = 0; m_bad = 0;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge
    task automatic step();
        bit acc, rs;
        @(posedge clk);
        m_edges++;
        rs = (edit_en && !m_prev_en) || (edit_sel != m_prev_sel);
        m_blink_t = rs ? 0 : m_blink_t + 1;
        acc = time_valid;
`ifdef FMT_BCD_CHECK_EN
        if (time_valid && !bcd_valid(sec, min, hour)) begin
            acc = 0;
            m_bad = 1;
        end
`endif
        if (acc) begin
            m_h = hour; m_m = min; m_s = sec;
            m_since_tv = 0;
            m_have = 1;
        end else begin
            m_since_tv++;
        end
        if (mode_btn) m_ms = !m_ms;
        m_prev_en = edit_en;
        m_prev_sel = edit_sel;
        #1;
    endtask

    function automatic logic [35:0] exp_vec();
        bit         live, ph, sc, bhi, blo;
        logic [7:0] hi, lo, e3, e2, e1, e0;
        logic [1:0] dt;
        sc   = (m_edges % SDIV) == SDIV - 1;
        live = m_have && (m_since_tv < TSTALE);
        if (!live) return {32'h0F0F0F0F, 2'b11, 1'b1, sc};
        ph  = ((m_blink_t / BDIV) % 2) == 0;
        hi  = m_ms ? m_m : m_h;
        lo  = m_ms ? m_s : m_m;
        bhi = edit_en && !ph && (edit_sel == (m_ms ? 2'd1 : 2'd2));
        blo = edit_en && !ph && (edit_sel == (m_ms ? 2'd0 : 2'd1));
        e3  = bhi ? 8'h0F : {4'h0, hi[7:4]};
        e2  = bhi ? 8'h0F : {4'h0, hi[3:0]};
        e1  = blo ? 8'h0F : {4'h0, lo[7:4]};
        e0  = blo ? 8'h0F : {4'h0, lo[3:0]};
        dt  = {(edit_en || ph) ? 1'b0 : 1'b1, edit_en ? 1'b0 : 1'b1};
        return {e3, e2, e1, e0, dt, 1'b0, sc};
    endfunction

    function automatic logic [7:0] rand_bcd(input int maxv);
        int v;
        v = $urandom_range(0, maxv);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        time_valid = 0; mode_btn = 0; edit_en = 0; edit_sel = 2'd3;
        sec = 0; min = 0; hour = 0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (got !== {32'h0F0F0F0F, 2'b11, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", got, {32'h0F0F0F0F, 2'b11, 1'b1, 1'b0});
        end
`ifdef FMT_BCD_CHECK_EN
        checks++;
        if (bad_bcd !== 1'b0) begin
            errors++;
            $display("FAIL reset_bad_bcd got=%b exp=0", bad_bcd);
        end
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3 * SDIV + 3; i++) begin
            step();
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, got, exp_vec());
            end
        end
    endtask

    task automatic test_snapshot();
        time_valid = 1; hour = 8'h12; min = 8'h34; sec = 8'h56;
        step();
        time_valid = 0;
        checks++;
        if ({d3, d2, d1, d0, stale} !== {32'h01020304, 1'b0}) begin
            errors++;
            $display("FAIL snapshot_hm got=%h exp=%h", {d3, d2, d1, d0, stale}, {32'h01020304, 1'b0});
        end
        mode_btn = 1;
        step();
        mode_btn = 0;
        checks++;
        if ({d3, d2, d1, d0} !== 32'h03040506) begin
            errors++;
            $display("FAIL snapshot_ms got=%h exp=03040506", {d3, d2, d1, d0});
        end
        mode_btn = 1;
        step();
        mode_btn = 0;
        checks++;
        if (got !== exp_vec()) begin
            errors++;
            $display("FAIL snapshot_back_hm got=%h exp=%h", got, exp_vec());
        end
    endtask

    task automatic test_edit();
        edit_en = 1; edit_sel = 2'd1;
        for (int i = 0; i < 3 * BDIV + 7; i++) begin
            step();
            time_valid = (i % 100 == 50);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL edit_min cyc=%0d got=%h exp=%h", i, got, exp_vec());
            end
        end
        time_valid = 0;
        edit_sel = 2'd2;
        step();
        checks++;
        if ({d3, d2, dot} !== {8'h01, 8'h02, 2'b00}) begin
            errors++;
            $display("FAIL edit_sel_restart got=%h exp=%h", {d3, d2, dot}, {8'h01, 8'h02, 2'b00});
        end
        for (int i = 0; i < 2 * BDIV + 5; i++) begin
            step();
            time_valid = (i % 100 == 50);
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL edit_hour cyc=%0d got=%h exp=%h", i, got, exp_vec());
            end
        end
        time_valid = 0; edit_en = 0; edit_sel = 2'd3;
        step();
    endtask

    task automatic test_stale();
        time_valid = 1; hour = 8'h12; min = 8'h34; sec = 8'h56;
        step();
        time_valid = 0;
        for (int i = 0; i < TSTALE + 10; i++) begin
            step();
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL stale_run cyc=%0d got=%h exp=%h", i, got, exp_vec());
            end
        end
        checks++;
        if ({d3, d2, d1, d0, dot, stale} !== {32'h0F0F0F0F, 2'b11, 1'b1}) begin
            errors++;
            $display("FAIL stale_blank got=%h exp=%h", {d3, d2, d1, d0, dot, stale},
                     {32'h0F0F0F0F, 2'b11, 1'b1});
        end
        time_valid = 1;
        step();
        time_valid = 0;
        checks++;
        if ({d3, d2, d1, d0, stale} !== {32'h01020304, 1'b0}) begin
            errors++;
            $display("FAIL stale_restore got=%h exp=%h", {d3, d2, d1, d0, stale}, {32'h01020304, 1'b0});
        end
    endtask

    task automatic test_same_cycle();
        time_valid = 1; mode_btn = 1; hour = 8'h23; min = 8'h59; sec = 8'h07;
        step();
        time_valid = 0; mode_btn = 0;
        checks++;
        if ({d3, d2, d1, d0} !== 32'h05090007) begin
            errors++;
            $display("FAIL same_cycle got=%h exp=05090007", {d3, d2, d1, d0});
        end
        mode_btn = 1;
        step();
        mode_btn = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            time_valid = 1; hour = rand_bcd(23); min = rand_bcd(59); sec = rand_bcd(59);
            mode_btn = (i == 4);
            step();
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back i=%0d got=%h exp=%h", i, got, exp_vec());
            end
        end
        time_valid = 0; mode_btn = 0;
    endtask

`ifdef FMT_BCD_CHECK_EN
    task automatic test_bcd();
        time_valid = 1; hour = 8'h12; min = 8'h7A; sec = 8'h00;
        step();
        time_valid = 0;
        checks++;
        if ({got, bad_bcd} !== {exp_vec(), 1'b1}) begin
            errors++;
            $display("FAIL bcd_reject got=%h exp=%h", {got, bad_bcd}, {exp_vec(), 1'b1});
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (bad_bcd !== 1'b1) begin
            errors++;
            $display("FAIL bcd_sticky got=%b exp=1", bad_bcd);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            // Middle third starves time_valid so stale periods occur
            if (i >= 1000 && i < 2000) time_valid = ($urandom_range(0, 499) == 0);
            else                       time_valid = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) begin
                hour = 8'($urandom_range(0, 255));
                min  = 8'($urandom_range(0, 255));
                sec  = 8'($urandom_range(0, 255));
            end else begin
                hour = rand_bcd(23); min = rand_bcd(59); sec = rand_bcd(59);
            end
            mode_btn = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) edit_en = !edit_en;
            if ($urandom_range(0, 149) == 0) edit_sel = 2'($urandom_range(0, 3));
            step();
            checks++;
            if (got !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp_vec());
            end
        end
        time_valid = 0; mode_btn = 0;
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_edit();
        test_stale();
        test_same_cycle();
        test_back_to_back();
`ifdef FMT_BCD_CHECK_EN
        test_bcd();
`endif
        test_random();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
